seg_scan_decoder: RTL
=====================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 3: consecutive identical samples required before a digit is accepted (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 16'd50000: wei_clk cycles without a completed frame before stale asserts.
REQ-003 SHALL have port wei_clk, input, 1: sampling clock, rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port wei_en, input, 4: observed digit select (0111 = low digit, 1011 = high digit, active-low).
REQ-006 SHALL have port duan, input, 8: observed active-low segment code.
REQ-007 SHALL have port data, output, 8: recovered BCD pair {high, low}.
REQ-008 SHALL have port data_valid, output, 1: one-cycle pulse when data updates.
REQ-009 SHALL have port code_err, output, 1: one-cycle pulse when an accepted digit carries an unknown code.
REQ-010 SHALL have port stale, output, 1: level; no complete frame within TIMEOUT.

Function
REQ-011 SHALL pass wei_en and duan through a 2-flop synchronizer; all later logic uses synchronized values only.
REQ-012 SHALL keep a saturating stability counter: increment when {wei_en,duan} equals the previous sample, else clear to 0.
REQ-013 SHALL generate exactly one accept per digit dwell, in the cycle the counter reaches STABLE_CNT-1; no re-accept until the sample changes.
REQ-014 SHALL ignore wei_en values other than 0111 and 1011; those samples still clear the counter.
REQ-015 SHALL decode c0,f9,a4,b0,99,92,82,f8,80,90 to 0..9; any other code decodes to 0 and pulses code_err in the accept cycle.
REQ-016 SHALL implement FSM WAIT_LO/WAIT_HI. WAIT_LO: low accept stores lo_reg, goes WAIT_HI; high accept ignored.
REQ-017 SHALL, in WAIT_HI: high accept loads data={hi,lo_reg} and pulses data_valid next cycle, returns WAIT_LO; low accept overwrites lo_reg, stays.
REQ-018 SHALL complete a frame with an invalid digit (nibble 0) rather than drop it.
REQ-019 SHALL hold data between frames; data_valid and code_err never high two consecutive cycles.
REQ-020 SHALL give latency: input change to data_valid = 2 (sync) + STABLE_CNT + 1 cycles for the high digit.

Reset
REQ-021 SHALL on rst low asynchronously clear: sync flops to wei_en=1111/duan=ff, counter 0, lo_reg 0, data 8'h00, data_valid 0, code_err 0, stale 0, FSM WAIT_LO, watchdog 0.
REQ-022 SHALL discard any partial frame on reset mid-operation; first high digit after release is ignored until a low digit is accepted.

Configuration
REQ-023 SHALL with SEG_SCAN_TIMEOUT_EN defined include a 16-bit watchdog cleared on data_valid, incremented otherwise, saturating; stale = (watchdog >= TIMEOUT).
REQ-024 SHALL without SEG_SCAN_TIMEOUT_EN omit the watchdog and tie stale to 0.

Structure
REQ-025 SHALL place segment code constants, digit-select constants (0111, 1011) and the FSM state encoding in shared package seg_pkg.
REQ-026 SHALL implement synchronizer plus stability counter plus accept generation as sub-module seg_stable_filter; FSM, decode and watchdog stay in top.

Verification
REQ-027 SHALL cover: alternate 0111/f9 and 1011/a4, 10 cycles each -> data=8'h21, one data_valid per pair, code_err never.
REQ-028 SHALL cover: duan glitch held 2 cycles with STABLE_CNT=3 -> no accept; held 3 cycles -> accept.
REQ-029 SHALL cover: low digit duan=8'hff -> code_err pulse, frame completes with low nibble 0.
REQ-030 SHALL cover: rst low while in WAIT_HI -> outputs at reset values; first post-reset high digit ignored; next full pair updates data.
REQ-031 SHALL cover: wei_en=1111 for TIMEOUT cycles with macro defined -> stale=1; next frame -> stale=0; without macro stale stays 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan decoder: digit-select patterns,
// active-low segment codes for 0..9 and the frame FSM state encoding.
package seg_pkg;

  // Active-low digit selects as seen on wei_en
  localparam logic [3:0] SelLo   = 4'b0111;
  localparam logic [3:0] SelHi   = 4'b1011;
  localparam logic [3:0] SelIdle = 4'b1111;

  // Active-low segment codes (dp off) for digits 0..9
  localparam logic [7:0] Seg0     = 8'hc0;
  localparam logic [7:0] Seg1     = 8'hf9;
  localparam logic [7:0] Seg2     = 8'ha4;
  localparam logic [7:0] Seg3     = 8'hb0;
  localparam logic [7:0] Seg4     = 8'h99;
  localparam logic [7:0] Seg5     = 8'h92;
  localparam logic [7:0] Seg6     = 8'h82;
  localparam logic [7:0] Seg7     = 8'hf8;
  localparam logic [7:0] Seg8     = 8'h80;
  localparam logic [7:0] Seg9     = 8'h90;
  localparam logic [7:0] SegBlank = 8'hff;

  // Frame assembly: wait for the low digit, then the high digit
  typedef enum logic {
    StWaitLo = 1'b0,
    StWaitHi = 1'b1
  } state_e;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Signal bundle between an observed multiplexed display and its decoder.
// The decoder side uses the slave modport; the display/stimulus side uses master.
interface seg_scan_decoder_if;
  logic [3:0] wei_en;
  logic [7:0] duan;
  logic [7:0] data;
  logic       data_valid;
  logic       code_err;
  logic       stale;

  modport master (
    output wei_en, duan,
    input  data, data_valid, code_err, stale
  );

  modport slave (
    input  wei_en, duan,
    output data, data_valid, code_err, stale
  );
endinterface

// File: rtl/seg_stable_filter.sv
// Two-flop synchronizer for {wei_en, duan}, a saturating stability counter and
// a single accept pulse per stable digit dwell.
module seg_stable_filter
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic       wei_clk,
  input  logic       rst,
  input  logic [3:0] wei_en_i,
  input  logic [7:0] duan_i,
  output logic       acc_o,
  output logic       acc_hi_o,
  output logic [7:0] acc_seg_o
);

  localparam logic [3:0]  AccCnt  = 4'(STABLE_CNT - 1);
  localparam logic [11:0] IdleSmp = {SelIdle, SegBlank};

  logic [11:0] sync1_q, sync2_q, prev_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        smp_sel_ok, prev_sel_ok;

  assign smp_sel_ok  = (sync2_q[11:8] == SelLo) || (sync2_q[11:8] == SelHi);
  assign prev_sel_ok = (prev_q[11:8] == SelLo) || (prev_q[11:8] == SelHi);

  // Counter tracks how long prev_q has been repeated; unknown selects hold it at 0.
  always_comb begin
    cnt_d = 4'd0;
    if ((sync2_q == prev_q) && smp_sel_ok) begin
      cnt_d = (cnt_q == 4'hf) ? cnt_q : cnt_q + 4'd1;
    end
  end

  // Synchronizer, previous-sample and counter registers.
  always_ff @(posedge wei_clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= IdleSmp;
      sync2_q <= IdleSmp;
      prev_q  <= IdleSmp;
      cnt_q   <= 4'd0;
    end else begin
      sync1_q <= {wei_en_i, duan_i};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  // The counter passes AccCnt only once per dwell, so this is a single pulse.
  assign acc_o     = (cnt_q == AccCnt) && prev_sel_ok;
  assign acc_hi_o  = (prev_q[11:8] == SelHi);
  assign acc_seg_o = prev_q[7:0];

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers a two-digit BCD value by snooping a multiplexed seven-segment
// display. Optional watchdog enabled with `define SEG_SCAN_TIMEOUT_EN; without
// it, stale is tied low.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 3,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic                wei_clk,
  input  logic                rst,
  seg_scan_decoder_if.slave   bus_io
);

  logic       acc, acc_hi;
  logic [7:0] acc_seg;
  logic [3:0] digit;
  logic       known;

  state_e     state_q, state_d;
  logic [3:0] lo_q, lo_d;
  logic [7:0] data_q, data_d;
  logic       dv_q, dv_d;

  seg_stable_filter #(
    .STABLE_CNT (STABLE_CNT)
  ) u_filter (
    .wei_clk   (wei_clk),
    .rst       (rst),
    .wei_en_i  (bus_io.wei_en),
    .duan_i    (bus_io.duan),
    .acc_o     (acc),
    .acc_hi_o  (acc_hi),
    .acc_seg_o (acc_seg)
  );

  // Segment code to BCD; unknown codes become 0 and are flagged.
  always_comb begin
    digit = 4'd0;
    known = 1'b1;
    case (acc_seg)
      Seg0:    digit = 4'd0;
      Seg1:    digit = 4'd1;
      Seg2:    digit = 4'd2;
      Seg3:    digit = 4'd3;
      Seg4:    digit = 4'd4;
      Seg5:    digit = 4'd5;
      Seg6:    digit = 4'd6;
      Seg7:    digit = 4'd7;
      Seg8:    digit = 4'd8;
      Seg9:    digit = 4'd9;
      default: known = 1'b0;
    endcase
  end

  // Frame FSM: low digit first, high digit completes the frame.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    unique case (state_q)
      StWaitLo: begin
        if (acc && !acc_hi) begin
          lo_d    = digit;
          state_d = StWaitHi;
        end
      end
      StWaitHi: begin
        if (acc && acc_hi) begin
          data_d  = {digit, lo_q};
          dv_d    = 1'b1;
          state_d = StWaitLo;
        end else if (acc) begin
          lo_d = digit;
        end
      end
      default: state_d = StWaitLo;
    endcase
  end

  // Frame state and output registers.
  always_ff @(posedge wei_clk or negedge rst) begin
    if (!rst) begin
      state_q <= StWaitLo;
      lo_q    <= 4'd0;
      data_q  <= 8'h00;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
    end
  end

  assign bus_io.data       = data_q;
  assign bus_io.data_valid = dv_q;
  assign bus_io.code_err   = acc && !known;

`ifdef SEG_SCAN_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;

  // Watchdog: cycles since the last completed frame, saturating.
  always_comb begin
    wdog_d = wdog_q;
    if (dv_q) begin
      wdog_d = 16'd0;
    end else if (wdog_q != 16'hffff) begin
      wdog_d = wdog_q + 16'd1;
    end
  end

  // Watchdog register.
  always_ff @(posedge wei_clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= 16'd0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign bus_io.stale = (wdog_q >= TIMEOUT);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign bus_io.stale   = 1'b0;
`endif

endmodule
